irq_encoder_8to3: RTL and testbench

- Registered 8-to-3 priority encoder with handshake; the inverse of the team's active-low 3-to-8 decoder.
- Collects eight active-low request lines and synchronizes them.
- Holds pending requests and presents the highest-priority pending index as a 3-bit code over a valid/ready handshake.
- Sits between asynchronous request sources (or a 3-to-8 decoder output bus, for loop-back) and the sequencer that services them.

---
 rtl/irq_encoder_8to3_pkg.sv | 18 +
 rtl/irq_encoder_8to3_sync.sv | 39 +++
 rtl/irq_encoder_8to3.sv | 160 ++++++++++++++++
 tb/tb_irq_encoder_8to3.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/irq_encoder_8to3_pkg.sv
// ---------------------------------------------------------------------------
// irq_encoder_8to3_pkg
// Shared constants for the registered 8-to-3 interrupt priority encoder:
// bus widths, FSM state encoding and the synchronizer reset value.
// ---------------------------------------------------------------------------
package irq_encoder_8to3_pkg;

    localparam int CODE_W = 3;
    localparam int REQ_W  = 8;

    // Offer FSM state encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

    // Active-low requests: synchronizer resets to "nothing requested"
    localparam logic [REQ_W-1:0] SYNC_RST_VAL = 8'hFF;

endpackage

// File: rtl/irq_encoder_8to3_sync.sv
// ---------------------------------------------------------------------------
// sync_bus
// Multi-flop synchronizer for a bus of independent asynchronous bits.
// Ports:
//   clk    in   sampling clock
//   rst_n  in   asynchronous active-low reset, loads RST_VAL into every stage
//   d      in   WIDTH-bit asynchronous input
//   q      out  WIDTH-bit synchronized output (DEPTH clocks behind d)
// ---------------------------------------------------------------------------
module sync_bus #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift chain: stage 0 samples the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= RST_VAL;
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/irq_encoder_8to3.sv
// ---------------------------------------------------------------------------
// irq_encoder_8to3
// Registered 8-to-3 priority encoder with valid/ready handshake. Eight
// active-low asynchronous request lines are synchronized, held as pending
// bits (edge mode) or followed directly (level mode), and the highest
// unmasked pending index is offered as a 3-bit code.
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   req_n[7:0]   in   active-low requests, bit 7 highest priority
//   mask[7:0]    in   1 = bit excluded from selection (still latched)
//   en           in   1 = a new offer may start
//   code[2:0]    out  offered request index
//   valid        out  code is valid
//   ready        in   consumer takes code when valid && ready
//   any_pending  out  registered OR of unmasked pending bits
//   overrun      out  one-cycle pulse: edge on an already-pending bit
// ---------------------------------------------------------------------------
module irq_encoder_8to3
    import irq_encoder_8to3_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LEVEL_MODE  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REQ_W-1:0]  req_n,
    input  logic [REQ_W-1:0]  mask,
    input  logic              en,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    input  logic              ready,
    output logic              any_pending,
    output logic              overrun
);

    // Fewer than two stages is not a safe synchronizer; clamp silently.
    localparam int SYNC_DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [REQ_W-1:0]  s_n_s;
    logic [REQ_W-1:0]  prev_n_r;
    logic [REQ_W-1:0]  pending_r;
    logic [REQ_W-1:0]  pending_s;
    logic [REQ_W-1:0]  fall_s;
    logic [REQ_W-1:0]  clr_s;
    logic [REQ_W-1:0]  eligible_s;
    logic              accept_s;
    logic [0:0]        state_r;
    logic [CODE_W-1:0] code_r;
    logic              valid_r;
    logic              any_pending_r;
    logic              overrun_r;

    // Highest set bit wins; later loop iterations overwrite earlier ones.
    function automatic logic [CODE_W-1:0] prio_index(input logic [REQ_W-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = {CODE_W{1'b0}};
        for (int i = 0; i < REQ_W; i++) begin
            if (v[i]) begin
                idx = CODE_W'(i);
            end
        end
        return idx;
    endfunction

    sync_bus #(
        .WIDTH   (REQ_W),
        .DEPTH   (SYNC_DEPTH),
        .RST_VAL (SYNC_RST_VAL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (req_n),
        .q     (s_n_s)
    );

    // Edge detect, accept decode and selection of eligible requests
    always_comb begin
        fall_s   = prev_n_r & ~s_n_s;
        accept_s = valid_r & ready;
        clr_s    = {REQ_W{1'b0}};
        if (accept_s) begin
            clr_s[code_r] = 1'b1;
        end else begin
            clr_s = {REQ_W{1'b0}};
        end
        if (LEVEL_MODE != 0) begin
            pending_s = ~s_n_s;
        end else begin
            pending_s = pending_r;
        end
        eligible_s = pending_s & ~mask;
    end

    // Pending storage: a new falling edge beats a same-cycle accept clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_n_r  <= SYNC_RST_VAL;
            pending_r <= {REQ_W{1'b0}};
            overrun_r <= 1'b0;
        end else begin
            prev_n_r <= s_n_s;
            if (LEVEL_MODE != 0) begin
                pending_r <= {REQ_W{1'b0}};
                overrun_r <= 1'b0;
            end else begin
                pending_r <= (pending_r & ~clr_s) | fall_s;
                overrun_r <= |(fall_s & pending_r);
            end
        end
    end

    // Summary flag, one clock behind pending/mask
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_pending_r <= 1'b0;
        end else begin
            any_pending_r <= |eligible_s;
        end
    end

    // Offer FSM: code is frozen for the whole OFFER state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            code_r  <= {CODE_W{1'b0}};
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (en && (|eligible_s)) begin
                        code_r  <= prio_index(eligible_s);
                        valid_r <= 1'b1;
                        state_r <= ST_OFFER;
                    end else begin
                        valid_r <= 1'b0;
                    end
                end
                ST_OFFER: begin
                    if (accept_s) begin
                        valid_r <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign code        = code_r;
    assign valid       = valid_r;
    assign any_pending = any_pending_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_irq_encoder_8to3.sv
module tb_irq_encoder_8to3;

    typedef struct {
        logic [7:0] req_n;
        logic [7:0] mask;
        logic       en;
        logic       ready;
        logic       e_valid;
        logic [2:0] e_code;
        logic       e_any;
        logic       e_ovr;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_n;
    logic [7:0] mask;
    logic       en;
    logic       ready;
    logic [2:0] code;
    logic       valid;
    logic       any_pending;
    logic       overrun;

    logic [7:0] req_n_l;
    logic       ready_l;
    logic [2:0] code_l;
    logic       valid_l;
    logic       any_pending_l;
    logic       overrun_l;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    irq_encoder_8to3 #(.SYNC_STAGES(2), .LEVEL_MODE(0)) dut_edge (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_n       (req_n),
        .mask        (mask),
        .en          (en),
        .code        (code),
        .valid       (valid),
        .ready       (ready),
        .any_pending (any_pending),
        .overrun     (overrun)
    );

    irq_encoder_8to3 #(.SYNC_STAGES(2), .LEVEL_MODE(1)) dut_level (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_n       (req_n_l),
        .mask        (mask),
        .en          (en),
        .code        (code_l),
        .valid       (valid_l),
        .ready       (ready_l),
        .any_pending (any_pending_l),
        .overrun     (overrun_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] r, input logic [7:0] m, input logic e, input logic rd,
                       input logic v, input logic [2:0] c, input logic a, input logic o);
        vec_t t;
        t.req_n = r; t.mask = m; t.en = e; t.ready = rd;
        t.e_valid = v; t.e_code = c; t.e_any = a; t.e_ovr = o;
        vecs.push_back(t);
    endtask

    initial begin
        rst_n = 1'b0; req_n = 8'hFF; mask = 8'h00; en = 1'b1; ready = 1'b0;
        req_n_l = 8'hFF; ready_l = 1'b0;

        // ---- idle after reset
        for (int i = 0; i < 20; i++) add(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        // ---- single request on bit 3, ready held high
        for (int i = 0; i < 3; i++) add(8'hF7, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        add(8'hF7, 8'h00, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
        add(8'hF7, 8'h00, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) add(8'hF7, 8'h00, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) add(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0);
        // ---- bits 6,5,1 together, stalled then drained in order
        for (int i = 0; i < 3; i++) add(8'h9D, 8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) add(8'h9D, 8'h00, 1'b1, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0);
        add(8'h9D, 8'h00, 1'b1, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0);
        add(8'h9D, 8'h00, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0);
        add(8'h9D, 8'h00, 1'b1, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0);
        add(8'h9D, 8'h00, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
        add(8'h9D, 8'h00, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0);
        add(8'h9D, 8'h00, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) add(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
        // ---- mask and en: bits 7 and 2, bit 7 masked first
        for (int i = 0; i < 3; i++) add(8'h7B, 8'h80, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
        add(8'h7B, 8'h80, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
        add(8'h7B, 8'h80, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0);
        add(8'h7B, 8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0);
        add(8'h7B, 8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0);
        add(8'h7B, 8'h00, 1'b1, 1'b0, 1'b1, 3'd7, 1'b1, 1'b0);
        add(8'h7B, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0);
        add(8'h7B, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0);
        add(8'h7B, 8'h00, 1'b1, 1'b1, 1'b0, 3'd7, 1'b1, 1'b0);
        add(8'h7B, 8'h00, 1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) add(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0);
        // ---- overrun on bit 4, then an edge landing on its accept
        for (int i = 0; i < 3; i++) add(8'hEF, 8'h00, 1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0);
        add(8'hEF, 8'h00, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
        add(8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
        add(8'hEF, 8'h00, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
        add(8'hEF, 8'h00, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
        add(8'hEF, 8'h00, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1);
        add(8'hEF, 8'h00, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
        add(8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
        add(8'hEF, 8'h00, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
        add(8'hEF, 8'h00, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
        add(8'hEF, 8'h00, 1'b1, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1);
        add(8'hEF, 8'h00, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
        add(8'hEF, 8'h00, 1'b1, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0);
        add(8'hEF, 8'h00, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) add(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);

        // ---- reset state, including across reset release
        tick(); tick();
        chk("rst_valid", {7'd0, valid}, 8'd0);
        chk("rst_code", {5'd0, code}, 8'd0);
        chk("rst_any", {7'd0, any_pending}, 8'd0);
        chk("rst_ovr", {7'd0, overrun}, 8'd0);
        chk("rst_level_valid", {7'd0, valid_l}, 8'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_valid", {7'd0, valid}, 8'd0);
        chk("rel_any", {7'd0, any_pending}, 8'd0);

        // ---- table-driven edge-mode vectors
        for (int i = 0; i < vecs.size(); i++) begin
            req_n = vecs[i].req_n; mask = vecs[i].mask;
            en = vecs[i].en; ready = vecs[i].ready;
            tick();
            chk($sformatf("row%0d_valid", i), {7'd0, valid}, {7'd0, vecs[i].e_valid});
            chk($sformatf("row%0d_code", i), {5'd0, code}, {5'd0, vecs[i].e_code});
            chk($sformatf("row%0d_any", i), {7'd0, any_pending}, {7'd0, vecs[i].e_any});
            chk($sformatf("row%0d_ovr", i), {7'd0, overrun}, {7'd0, vecs[i].e_ovr});
        end

        // ---- reset pulsed during an offer
        req_n = 8'h7F; mask = 8'h00; en = 1'b1; ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_offer_valid", {7'd0, valid}, 8'd1);
        chk("mid_offer_code", {5'd0, code}, 8'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {7'd0, valid}, 8'd0);
        chk("async_rst_code", {5'd0, code}, 8'd0);
        chk("async_rst_any", {7'd0, any_pending}, 8'd0);
        req_n = 8'hFF;
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("post_rst%0d_valid", i), {7'd0, valid}, 8'd0);
            chk($sformatf("post_rst%0d_any", i), {7'd0, any_pending}, 8'd0);
        end

        // ---- level mode: bit 0 held low re-offers every other cycle
        req_n_l = 8'hFE; ready_l = 1'b1;
        tick(); tick(); tick();
        chk("lvl_first_valid", {7'd0, valid_l}, 8'd1);
        chk("lvl_first_code", {5'd0, code_l}, 8'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("lvl%0d_valid", i), {7'd0, valid_l}, {7'd0, (i % 2 == 1) ? 1'b1 : 1'b0});
            chk($sformatf("lvl%0d_code", i), {5'd0, code_l}, 8'd0);
            chk($sformatf("lvl%0d_any", i), {7'd0, any_pending_l}, 8'd1);
            chk($sformatf("lvl%0d_ovr", i), {7'd0, overrun_l}, 8'd0);
        end
        req_n_l = 8'hFF;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("lvl_rel%0d_valid", i), {7'd0, valid_l}, 8'd0);
            chk($sformatf("lvl_rel%0d_any", i), {7'd0, any_pending_l}, 8'd0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
